// File: rtl/fifo_burst_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_burst_scheduler
//
// Moves data burst by burst from the UART RX FIFO, through the fixed-latency
// image-processing pipeline, and into the UART TX FIFO. It is driven only by
// the FIFO full/empty flags:
//   IDLE  -> waits for a full RX FIFO and an empty TX FIFO
//   READ  -> reads BURST words (stalls while the RX FIFO reports empty)
//   FLUSH -> waits PROC_LAT cycles for the pipeline to drain into the TX FIFO
//   DRAIN -> enables the UART transmitter until the TX FIFO is empty
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   rx_full         RX FIFO full
//   rx_empty        RX FIFO empty
//   rx_data         RX FIFO show-ahead read data
//   rx_rd           RX FIFO read strobe
//   proc_din        pipeline input data (rx_data passed straight through)
//   proc_valid_in   pipeline input valid (same cycle as rx_rd)
//   proc_dout       pipeline output data
//   proc_valid_out  pipeline output valid
//   tx_full         TX FIFO full
//   tx_empty        TX FIFO empty
//   tx_wr           TX FIFO write strobe
//   tx_wdata        TX FIFO write data
//   tx_en           UART transmitter enable (registered, high during DRAIN)
//   busy            high whenever the scheduler is not IDLE
//   burst_done      one-cycle pulse in the IDLE cycle that ends a burst
//   overflow_err    sticky: a pipeline output arrived while the TX FIFO was full
// ---------------------------------------------------------------------------
module fifo_burst_scheduler #(
    parameter int DATA_W   = 8,
    parameter int BURST    = 16,
    parameter int CNT_W    = 5,
    parameter int PROC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_full,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_rd,
    output logic [DATA_W-1:0] proc_din,
    output logic              proc_valid_in,
    input  logic [DATA_W-1:0] proc_dout,
    input  logic              proc_valid_out,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic              tx_wr,
    output logic [DATA_W-1:0] tx_wdata,
    output logic              tx_en,
    output logic              busy,
    output logic              burst_done,
    output logic              overflow_err
);

    // Wide enough to hold PROC_LAT-1; at least one bit.
    localparam int LAT_W = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        FLUSH = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_next;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_next;
    logic             tx_en_next;
    logic             burst_done_next;

    // ---------------------------------------------------------------------
    // Datapath strobes. The RX read feeds the pipeline in the same cycle:
    // rx_data is show-ahead, so the word is valid alongside rx_rd.
    // ---------------------------------------------------------------------
    assign rx_rd         = (state == READ) && !rx_empty;
    assign proc_din      = rx_data;
    assign proc_valid_in = rx_rd;

    // The TX write path is independent of the FSM so that words still in the
    // pipeline land in the TX FIFO in any state. It is held off only while
    // reset is asserted; a word meeting a full TX FIFO is dropped and flagged.
    assign tx_wr    = reset && proc_valid_out && !tx_full;
    assign tx_wdata = proc_dout;

    assign busy = (state != IDLE);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next      = state;
        rd_cnt_next     = rd_cnt;
        lat_cnt_next    = lat_cnt;
        burst_done_next = 1'b0;

        case (state)
            IDLE: begin
                if (rx_full && tx_empty) begin
                    state_next  = READ;
                    rd_cnt_next = '0;
                end
            end

            READ: begin
                // An empty RX FIFO suppresses rx_rd, so the count and the
                // final-word transition both wait for a real read.
                if (rx_rd) begin
                    rd_cnt_next = rd_cnt + 1'b1;
                    if (rd_cnt == CNT_W'(BURST - 1)) begin
                        state_next   = FLUSH;
                        lat_cnt_next = LAT_W'(PROC_LAT - 1);
                    end
                end
            end

            FLUSH: begin
                // Loaded with PROC_LAT-1, so the dwell here is PROC_LAT cycles.
                if (lat_cnt == '0) begin
                    state_next = DRAIN;
                end else begin
                    lat_cnt_next = lat_cnt - 1'b1;
                end
            end

            DRAIN: begin
                if (tx_empty) begin
                    state_next      = IDLE;
                    burst_done_next = 1'b1;
                end
            end

            // Any encoding outside the four states recovers to IDLE.
            default: state_next = IDLE;
        endcase

        // Registered so tx_en is high exactly during DRAIN cycles.
        tx_en_next = (state_next == DRAIN);
    end

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            lat_cnt      <= '0;
            tx_en        <= 1'b0;
            burst_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state        <= state_next;
            rd_cnt       <= rd_cnt_next;
            lat_cnt      <= lat_cnt_next;
            tx_en        <= tx_en_next;
            burst_done   <= burst_done_next;
            overflow_err <= overflow_err | (proc_valid_out & tx_full);
        end
    end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_scheduler
//
// Directed bench for fifo_burst_scheduler. Around the DUT it provides:
//   - an RX FIFO stand-in whose show-ahead word is rx_base + (reads so far)
//   - a 2-cycle processing pipeline that outputs input+1
//   - a TX capture memory recording every tx_wr word
// Outputs are sampled at the falling edge (or shortly after it, when an
// input was just changed); inputs are driven at the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_burst_scheduler;

    localparam int DATA_W   = 8;
    localparam int BURST    = 16;
    localparam int CNT_W    = 5;
    localparam int PROC_LAT = 2;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              rx_full  = 1'b0;
    logic              rx_empty = 1'b0;
    logic              tx_full  = 1'b0;
    logic              tx_empty = 1'b0;
    logic              force_pv = 1'b0;
    logic [DATA_W-1:0] rx_base  = '0;

    logic [DATA_W-1:0] rx_data;
    logic              rx_rd;
    logic [DATA_W-1:0] proc_din;
    logic              proc_valid_in;
    logic [DATA_W-1:0] proc_dout;
    logic              proc_valid_out;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_wdata;
    logic              tx_en;
    logic              busy;
    logic              burst_done;
    logic              overflow_err;

    int vectors     = 0;
    int miscompares = 0;

    // RX FIFO stand-in and TX capture
    int                rx_reads = 0;
    int                n_got    = 0;
    logic [DATA_W-1:0] got_mem [0:511];

    // Pipeline model: two register stages, output = input + 1
    logic              p0_v = 1'b0, p1_v = 1'b0;
    logic [DATA_W-1:0] p0_d = '0,   p1_d = '0;

    always #5 clk = ~clk;

    assign rx_data        = rx_base + rx_reads[DATA_W-1:0];
    assign proc_valid_out = p1_v | force_pv;
    assign proc_dout      = force_pv ? 8'hEE : p1_d;

    always @(posedge clk) begin
        p0_v <= proc_valid_in;
        p0_d <= proc_din + 8'd1;
        p1_v <= p0_v;
        p1_d <= p0_d;
    end

    always @(posedge clk) begin
        if (rx_rd) rx_reads <= rx_reads + 1;
        if (tx_wr) begin
            got_mem[n_got[8:0]] <= tx_wdata;
            n_got               <= n_got + 1;
        end
    end

    fifo_burst_scheduler #(
        .DATA_W  (DATA_W),
        .BURST   (BURST),
        .CNT_W   (CNT_W),
        .PROC_LAT(PROC_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_full       (rx_full),
        .rx_empty      (rx_empty),
        .rx_data       (rx_data),
        .rx_rd         (rx_rd),
        .proc_din      (proc_din),
        .proc_valid_in (proc_valid_in),
        .proc_dout     (proc_dout),
        .proc_valid_out(proc_valid_out),
        .tx_full       (tx_full),
        .tx_empty      (tx_empty),
        .tx_wr         (tx_wr),
        .tx_wdata      (tx_wdata),
        .tx_en         (tx_en),
        .busy          (busy),
        .burst_done    (burst_done),
        .overflow_err  (overflow_err)
    );

    // -----------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside; they report what they saw)
    // -----------------------------------------------------------------------

    // Call at the falling edge where rx_full/tx_empty were just raised.
    // Runs the READ phase, optionally holding rx_empty high for stall_len
    // cycles once stall_after reads are done. Returns at the first falling
    // edge after the last read.
    task automatic read_phase(input int stall_after, input int stall_len,
                              output int reads, output int bad, output int cycles);
        int stalled;
        reads   = 0;
        bad     = 0;
        cycles  = 0;
        stalled = 0;
        @(negedge clk);
        rx_full  = 1'b0;
        tx_empty = 1'b0;
        while (reads < BURST && cycles < 100) begin
            if (reads == stall_after && stalled < stall_len) begin
                rx_empty = 1'b1;
                stalled++;
                #1;
                if (rx_rd) bad++;
                if (dut.rd_cnt !== CNT_W'(stall_after)) bad++;
            end else begin
                rx_empty = 1'b0;
                #1;
                if (rx_rd) reads++;
                else       bad++;
            end
            cycles++;
            @(negedge clk);
        end
        rx_empty = 1'b0;
    endtask

    // Checks FLUSH/DRAIN/IDLE sequencing and the words captured in the TX
    // FIFO for a burst whose first read was index r0 and first capture g0.
    task automatic flush_drain(input string tag, input int g0, input int r0);
        int                nbad;
        logic [DATA_W-1:0] exp_w, bad_got, bad_exp;
        // first FLUSH cycle
        vectors++;
        if ({rx_rd, busy, tx_en} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s flush1 {rx_rd,busy,tx_en}: got %b expected 010", tag, {rx_rd, busy, tx_en});
        end
        @(negedge clk);
        vectors++;
        if ({rx_rd, busy, tx_en} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s flush2 {rx_rd,busy,tx_en}: got %b expected 010", tag, {rx_rd, busy, tx_en});
        end
        @(negedge clk);
        vectors++;
        if ({busy, tx_en} !== 2'b11) begin
            miscompares++;
            $display("FAIL %s drain_start {busy,tx_en}: got %b expected 11", tag, {busy, tx_en});
        end
        // DRAIN holds while TX FIFO is not empty
        repeat (4) @(negedge clk);
        vectors++;
        if ({busy, tx_en, burst_done} !== 3'b110) begin
            miscompares++;
            $display("FAIL %s drain_hold {busy,tx_en,burst_done}: got %b expected 110", tag, {busy, tx_en, burst_done});
        end
        vectors++;
        if (n_got - g0 !== BURST) begin
            miscompares++;
            $display("FAIL %s tx_word_count: got %0d expected %0d", tag, n_got - g0, BURST);
        end
        nbad    = 0;
        bad_got = '0;
        bad_exp = '0;
        for (int i = 0; i < BURST; i++) begin
            exp_w = DATA_W'(int'(rx_base) + r0 + i + 1);
            if (got_mem[(g0 + i) & 511] !== exp_w) begin
                if (nbad == 0) begin
                    bad_got = got_mem[(g0 + i) & 511];
                    bad_exp = exp_w;
                end
                nbad++;
            end
        end
        vectors++;
        if (nbad != 0) begin
            miscompares++;
            $display("FAIL %s tx_data: %0d bad words, first got %0h expected %0h", tag, nbad, bad_got, bad_exp);
        end
        // TX FIFO drained
        tx_empty = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, tx_en, burst_done} !== 3'b001) begin
            miscompares++;
            $display("FAIL %s done {busy,tx_en,burst_done}: got %b expected 001", tag, {busy, tx_en, burst_done});
        end
        @(negedge clk);
        vectors++;
        if ({busy, tx_en, burst_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s after_done {busy,tx_en,burst_done}: got %b expected 000", tag, {busy, tx_en, burst_done});
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_rd, proc_valid_in, tx_wr, tx_en, busy, burst_done, overflow_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_held outputs: got %b expected 0000000",
                     {rx_rd, proc_valid_in, tx_wr, tx_en, busy, burst_done, overflow_err});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_rd, proc_valid_in, tx_wr, tx_en, busy, burst_done, overflow_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_released outputs: got %b expected 0000000",
                     {rx_rd, proc_valid_in, tx_wr, tx_en, busy, burst_done, overflow_err});
        end
    endtask

    task automatic test_burst();
        int reads, bad, cycles, g0, r0;
        rx_base  = 8'h10;
        g0       = n_got;
        r0       = rx_reads;
        rx_full  = 1'b1;
        tx_empty = 1'b1;
        read_phase(0, 0, reads, bad, cycles);
        vectors++;
        if (reads != BURST || bad != 0 || cycles != BURST) begin
            miscompares++;
            $display("FAIL burst_reads reads/gaps/cycles: got %0d/%0d/%0d expected 16/0/16", reads, bad, cycles);
        end
        flush_drain("burst", g0, r0);
    endtask

    task automatic test_rx_stall();
        int reads, bad, cycles, g0, r0;
        rx_base  = 8'h80;
        g0       = n_got;
        r0       = rx_reads;
        rx_full  = 1'b1;
        tx_empty = 1'b1;
        read_phase(5, 3, reads, bad, cycles);
        vectors++;
        if (reads != BURST || bad != 0 || cycles != BURST + 3) begin
            miscompares++;
            $display("FAIL stall_reads reads/errors/cycles: got %0d/%0d/%0d expected 16/0/19", reads, bad, cycles);
        end
        flush_drain("stall", g0, r0);
    endtask

    task automatic test_tx_not_empty();
        int reads, bad, cycles, g0, r0, seen;
        rx_base  = 8'h33;
        rx_full  = 1'b1;
        tx_empty = 1'b0;
        seen     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_rd || busy) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL hold_idle cycles with rx_rd/busy: got %0d expected 0", seen);
        end
        g0       = n_got;
        r0       = rx_reads;
        tx_empty = 1'b1;
        read_phase(0, 0, reads, bad, cycles);
        vectors++;
        if (reads != BURST || bad != 0 || cycles != BURST) begin
            miscompares++;
            $display("FAIL hold_then_read reads/gaps/cycles: got %0d/%0d/%0d expected 16/0/16", reads, bad, cycles);
        end
        flush_drain("hold", g0, r0);
    endtask

    task automatic test_overflow();
        int reads, bad, cycles, g0, r0;
        @(negedge clk);
        force_pv = 1'b1;
        tx_full  = 1'b1;
        #1;
        vectors++;
        if ({tx_wr, overflow_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_drop {tx_wr,overflow_err}: got %b expected 00", {tx_wr, overflow_err});
        end
        @(negedge clk);
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set overflow_err: got %b expected 1", overflow_err);
        end
        force_pv = 1'b0;
        tx_full  = 1'b0;
        repeat (100) @(negedge clk);
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky overflow_err: got %b expected 1", overflow_err);
        end
        rx_base  = 8'hF8;
        g0       = n_got;
        r0       = rx_reads;
        rx_full  = 1'b1;
        tx_empty = 1'b1;
        read_phase(0, 0, reads, bad, cycles);
        vectors++;
        if (reads != BURST || bad != 0) begin
            miscompares++;
            $display("FAIL ovf_burst reads/gaps: got %0d/%0d expected 16/0", reads, bad);
        end
        flush_drain("ovf", g0, r0);
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_after_burst overflow_err: got %b expected 1", overflow_err);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_reset overflow_err: got %b expected 0", overflow_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int reads, bad, cycles, g0, r0, n;
        rx_base  = 8'h40;
        tx_empty = 1'b0;
        @(negedge clk);
        rx_full  = 1'b1;
        tx_empty = 1'b1;
        @(negedge clk);
        rx_full  = 1'b0;
        tx_empty = 1'b0;
        n        = 0;
        for (int i = 0; i < 30 && n < 7; i++) begin
            #1;
            if (rx_rd) n++;
            if (n < 7) @(negedge clk);
        end
        vectors++;
        if (n != 7) begin
            miscompares++;
            $display("FAIL mid_reads before reset: got %0d expected 7", n);
        end
        // 7th read commits at this edge; reset lands between edges
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({rx_rd, proc_valid_in, tx_wr, busy, tx_en, burst_done} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_async_clear outputs: got %b expected 000000",
                     {rx_rd, proc_valid_in, tx_wr, busy, tx_en, burst_done});
        end
        vectors++;
        if (dut.rd_cnt !== '0) begin
            miscompares++;
            $display("FAIL mid_rd_cnt: got %0d expected 0", dut.rd_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_idle busy: got %b expected 0", busy);
        end
        g0       = n_got;
        r0       = rx_reads;
        rx_full  = 1'b1;
        tx_empty = 1'b1;
        read_phase(0, 0, reads, bad, cycles);
        vectors++;
        if (reads != BURST || bad != 0 || cycles != BURST) begin
            miscompares++;
            $display("FAIL mid_fresh reads/gaps/cycles: got %0d/%0d/%0d expected 16/0/16", reads, bad, cycles);
        end
        flush_drain("fresh", g0, r0);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_rx_stall();
        test_tx_not_empty();
        test_overflow();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_burst_scheduler.md
Name: fifo_burst_scheduler

Overview:
- Sequences the image-processing datapath between the UART RX FIFO and the UART TX FIFO, using only their full/empty flags.
- Waits until the RX FIFO is full and the TX FIFO is empty, then reads one burst of BURST words and streams them through the fixed-latency processing pipeline.
- Lets the pipeline flush, then enables the UART transmitter until the TX FIFO drains. Repeats burst by burst.

Parameters:
- DATA_W, 8: data word width.
- BURST, 16: words per burst; must equal RX FIFO depth and be <= TX FIFO depth.
- CNT_W, 5: burst counter width; must be >= clog2(BURST)+1.
- PROC_LAT, 2: fixed processing-pipeline latency in cycles (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_full  in  1  RX FIFO full.
- rx_empty  in  1  RX FIFO empty.
- rx_data  in  DATA_W  RX FIFO show-ahead read data.
- rx_rd  out  1  RX FIFO read strobe.
- proc_din  out  DATA_W  pipeline input data.
- proc_valid_in  out  1  pipeline input valid.
- proc_dout  in  DATA_W  pipeline output data.
- proc_valid_out  in  1  pipeline output valid.
- tx_full  in  1  TX FIFO full.
- tx_empty  in  1  TX FIFO empty.
- tx_wr  out  1  TX FIFO write strobe.
- tx_wdata  out  DATA_W  TX FIFO write data.
- tx_en  out  1  enables the UART transmitter to drain the TX FIFO.
- busy  out  1  high in any state other than IDLE.
- burst_done  out  1  one-cycle pulse when a burst completes.
- overflow_err  out  1  sticky error flag: a pipeline output arrived while the TX FIFO was full.

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0, tx_en=0, burst_done=0, overflow_err=0. rx_rd, proc_valid_in and tx_wr are 0 while reset is asserted. FIFO contents are not touched.
- The FSM has four states: IDLE, READ, FLUSH, DRAIN. state, rd_cnt, lat_cnt, tx_en and burst_done are registered.
- IDLE:
  - If rx_full && tx_empty at a rising edge, go to READ and clear rd_cnt.
  - Otherwise stay. rx_full with tx_empty=0 holds in IDLE.
- READ:
  - rx_rd = (state==READ) && !rx_empty, combinational.
  - proc_din = rx_data and proc_valid_in = rx_rd, same cycle; no added latency.
  - rd_cnt increments on each rx_rd.
  - When rx_rd is high and rd_cnt==BURST-1: go to FLUSH and load lat_cnt=PROC_LAT-1.
  - rx_empty=1 stalls: no read, rd_cnt holds.
- FLUSH: lat_cnt decrements each cycle. At lat_cnt==0, go to DRAIN. Total FLUSH dwell is PROC_LAT cycles.
- DRAIN:
  - tx_en=1 (registered; high starting the first DRAIN cycle).
  - When tx_empty=1, go to IDLE. tx_en drops to 0 in that IDLE cycle, and burst_done pulses for exactly that one cycle.
- TX write path (all states, combinational):
  - tx_wr = proc_valid_out && !tx_full; tx_wdata = proc_dout.
  - If proc_valid_out && tx_full: the word is dropped and overflow_err is set. It stays set until reset.
- busy = (state != IDLE).
- Simultaneous events:
  - rx_full asserting during READ, FLUSH or DRAIN is ignored until IDLE is re-entered. There is a minimum of one IDLE cycle between bursts.
  - rx_empty and the final count in the same cycle: no read, so no transition.
- Illegal or unused state encodings go to IDLE on the next clock.
- Reset mid-operation returns to IDLE immediately. In-flight pipeline outputs arriving after reset release are still written through tx_wr.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with all inputs 0 -> all outputs 0, busy=0, state remains IDLE.
2. Defaults, 2-cycle pipeline model: rx_full=1, tx_empty=1 -> exactly 16 consecutive rx_rd cycles starting the cycle after the edge that sampled rx_full. Then 2 FLUSH cycles, then tx_en=1. The model pushes 16 tx_wr words equal to rx_data+1. After the bench asserts tx_empty: tx_en=0 and a single burst_done pulse.
3. During READ, force rx_empty=1 for 3 cycles after the 5th read -> rx_rd low for those 3 cycles, rd_cnt holds at 5, still 16 reads in total, FLUSH entered after the 16th.
4. rx_full=1 with tx_empty=0 for 20 cycles -> rx_rd never asserts, busy=0. When tx_empty=1, READ starts on the next cycle.
5. Force tx_full=1 while proc_valid_out=1 -> tx_wr=0 and overflow_err=1, still 1 after 100 cycles and a new burst. Assert reset=0 -> overflow_err=0.
6. Assert reset=0 after the 7th read in READ -> outputs clear asynchronously. After release the FSM is in IDLE, and a new rx_full&&tx_empty starts a fresh 16-word burst.
